// File: rtl/decoder_3_8_seq_v_pkg.sv
// Shared constants and FSM encoding for the sequenced 3-to-8 decoder.
// The optional skid register is enabled by defining DECODER_SKID_EN.
package decoder_3_8_seq_v_pkg;

    localparam int DEC_N_IN = 3;
    localparam int CNT_W    = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } dec_state_e;

endpackage

// File: rtl/decoder_3_8_seq_v_hold_cnt.sv
// Loadable hold-time down-counter; saturates at zero and flags the last two counts.
module hold_cnt_v
    import decoder_3_8_seq_v_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero,
    output logic         o_one
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over decrement, and zero is sticky.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_val;
        end else if (i_dec && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_zero = (cnt_q == {W{1'b0}});
    assign o_one  = (cnt_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/decoder_3_8_seq_v.sv
// Sequenced 3-to-8 decoder: accepts a code over valid/ready and holds its one-hot line
// for HOLD_CYCLES cycles. Define DECODER_SKID_EN for a 1-entry skid enabling gapless codes.
module decoder_3_8_seq_v
    import decoder_3_8_seq_v_pkg::*;
#(
    parameter int N_IN        = DEC_N_IN,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_IN-1:0]       i_code,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [(1<<N_IN)-1:0]  o_line,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int               N_OUT    = 1 << N_IN;
    localparam logic [CNT_W-1:0] HOLD_M1  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic             HOLD_ONE = (HOLD_CYCLES == 1) ? 1'b1 : 1'b0;

    function automatic logic [N_OUT-1:0] onehot(input logic [N_IN-1:0] code);
        logic [N_OUT-1:0] v;
        v       = {N_OUT{1'b0}};
        v[code] = 1'b1;
        return v;
    endfunction

    dec_state_e        state_q, state_d;
    logic [N_OUT-1:0]  line_q, line_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept_s;
    logic              load_s;
    logic              dec_s;
    logic              cnt_zero_s;
    logic              cnt_one_s;
    logic              next_avail_s;
    logic [N_IN-1:0]   next_code_s;

    assign accept_s = i_valid & ready_q;

`ifdef DECODER_SKID_EN
    logic              skid_full_q, skid_full_d;
    logic [N_IN-1:0]   skid_code_q, skid_code_d;

    // A pending skid code takes precedence; otherwise a same-cycle accept follows directly.
    assign next_avail_s = skid_full_q | accept_s;
    assign next_code_s  = skid_full_q ? skid_code_q : i_code;

    // Skid fills on a mid-hold accept and refills if an accept lands while it drains.
    always_comb begin
        skid_full_d = skid_full_q;
        skid_code_d = skid_code_q;
        if ((state_q == ST_HOLD) && cnt_zero_s && skid_full_q) begin
            skid_full_d = accept_s;
            skid_code_d = accept_s ? i_code : skid_code_q;
        end else if ((state_q == ST_HOLD) && !cnt_zero_s && accept_s) begin
            skid_full_d = 1'b1;
            skid_code_d = i_code;
        end else begin
            skid_full_d = skid_full_q;
            skid_code_d = skid_code_q;
        end
    end

    // Skid storage; a pending code is dropped by reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            skid_full_q <= 1'b0;
            skid_code_q <= {N_IN{1'b0}};
        end else begin
            skid_full_q <= skid_full_d;
            skid_code_q <= skid_code_d;
        end
    end
`else
    assign next_avail_s = 1'b0;
    assign next_code_s  = i_code;
`endif

    hold_cnt_v #(
        .W (CNT_W)
    ) u_hold_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (load_s),
        .i_val   (HOLD_M1),
        .i_dec   (dec_s),
        .o_zero  (cnt_zero_s),
        .o_one   (cnt_one_s)
    );

    // FSM next state and the one-hot line to present next cycle.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        load_s  = 1'b0;
        dec_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_HOLD;
                    line_d  = onehot(i_code);
                    load_s  = 1'b1;
                end else begin
                    line_d  = {N_OUT{1'b0}};
                end
            end
            ST_HOLD: begin
                if (!cnt_zero_s) begin
                    dec_s   = 1'b1;
                end else if (next_avail_s) begin
                    line_d  = onehot(next_code_s);
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    line_d  = {N_OUT{1'b0}};
                end
            end
            default: begin
                state_d = ST_IDLE;
                line_d  = {N_OUT{1'b0}};
            end
        endcase
    end

    // Status outputs are precomputed one cycle ahead so they leave straight from flops.
    always_comb begin
        busy_d = (state_d == ST_HOLD);
        done_d = busy_d & (load_s ? HOLD_ONE : cnt_one_s);
`ifdef DECODER_SKID_EN
        ready_d = (state_d == ST_IDLE) | !skid_full_d | done_d;
`else
        ready_d = (state_d == ST_IDLE);
`endif
    end

    // State and output registers; ready stays low for the whole reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            line_q  <= {N_OUT{1'b0}};
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_ready = ready_q;
    assign o_line  = line_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_decoder_3_8_seq_v.sv
// Bench for decoder_3_8_seq_v: instance 0 holds 4 cycles, instance 1 holds 1 cycle.
// Builds against either DECODER_SKID_EN setting.
module tb_decoder_3_8_seq_v;

`ifdef DECODER_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic       clk = 1'b0;
    logic [1:0] rst_n_v;
    logic [1:0] valid_v;
    logic [2:0] code_v  [2];
    logic [7:0] line_v  [2];
    logic       ready_v [2];
    logic       busy_v  [2];
    logic       done_v  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decoder_3_8_seq_v #(.HOLD_CYCLES(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n_v[0]), .i_code(code_v[0]), .i_valid(valid_v[0]),
        .o_ready(ready_v[0]), .o_line(line_v[0]), .o_busy(busy_v[0]), .o_done(done_v[0]));

    decoder_3_8_seq_v #(.HOLD_CYCLES(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n_v[1]), .i_code(code_v[1]), .i_valid(valid_v[1]),
        .o_ready(ready_v[1]), .o_line(line_v[1]), .o_busy(busy_v[1]), .o_done(done_v[1]));

    // Reference model: a FIFO of accepted codes plus the active code and its remaining cycles.
    int m_hc  [2] = '{4, 1};
    int m_act [2];
    int m_cur [2];
    int m_rem [2];
    int m_qn  [2];
    int m_q   [2][2];
    int m_rok [2];
    int m_acc [2];

    function automatic logic m_ready(int k);
        if (m_rok[k] == 0) return 1'b0;
        if (SKID) return (m_act[k] == 0) || (m_qn[k] == 0) || (m_rem[k] == 1);
        else return (m_act[k] == 0);
    endfunction

    function automatic logic [7:0] m_line(int k);
        if (m_act[k] != 0) return 8'(32'd1 << m_cur[k]);
        else return 8'h00;
    endfunction

    function automatic void m_step(int k, logic rst_n, logic valid, int code);
        if (!rst_n) begin
            m_act[k] = 0; m_qn[k] = 0; m_rem[k] = 0; m_rok[k] = 0; m_acc[k] = 0;
        end else begin
            m_acc[k] = (valid && m_ready(k)) ? 1 : 0;
            if (m_acc[k] != 0) begin
                m_q[k][m_qn[k]] = code;
                m_qn[k]++;
            end
            if (m_act[k] != 0 && m_rem[k] > 1) begin
                m_rem[k]--;
            end else if (m_qn[k] > 0) begin
                m_cur[k] = m_q[k][0];
                m_q[k][0] = m_q[k][1];
                m_qn[k]--;
                m_act[k] = 1;
                m_rem[k] = m_hc[k];
            end else begin
                m_act[k] = 0;
            end
            m_rok[k] = 1;
        end
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) m_step(k, rst_n_v[k], valid_v[k], int'(code_v[k]));
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input int k);
        chk8($sformatf("u%0d_line", k), line_v[k], m_line(k));
        chk1($sformatf("u%0d_ready", k), ready_v[k], m_ready(k));
        chk1($sformatf("u%0d_busy", k), busy_v[k], m_act[k] != 0);
        chk1($sformatf("u%0d_done", k), done_v[k], (m_act[k] != 0) && (m_rem[k] == 1));
    endtask

    task automatic cyc();
        @(negedge clk);
        chk_model(0);
        chk_model(1);
    endtask

    typedef struct packed {
        logic       rst_n;
        logic       valid;
        logic [2:0] code;
        logic [7:0] line;
        logic       ready;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic v, logic [2:0] c, logic [7:0] l,
                                logic rdy, logic b, logic d);
        vec_t e;
        e.rst_n = r; e.valid = v; e.code = c; e.line = l;
        e.ready = rdy; e.busy = b; e.done = d;
        tbl.push_back(e);
    endfunction

    logic [7:0] seen[$];
    logic [7:0] nz[$];

    initial begin
        int gaps;
        int zrun;
        int dones;
        int held;
        int n;

        rst_n_v = 2'b00;
        valid_v = 2'b00;
        code_v[0] = 3'd0;
        code_v[1] = 3'd0;

        // Reset with valid high, release, then one code 5 held for 4 cycles.
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 3'd5, 8'h20, SKID, 1'b1, 1'b0);
        add(1'b1, 1'b0, 3'd0, 8'h20, SKID, 1'b1, 1'b0);
        add(1'b1, 1'b0, 3'd0, 8'h20, SKID, 1'b1, 1'b0);
        add(1'b1, 1'b0, 3'd0, 8'h20, SKID, 1'b1, 1'b1);
        add(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        // Back-to-back codes 2 then 6.
`ifdef DECODER_SKID_EN
        add(1'b1, 1'b1, 3'd2, 8'h04, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b1, 3'd6, 8'h04, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 3'd0, 8'h04, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 3'd0, 8'h04, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 3'd0, 8'h40, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 3'd0, 8'h40, 1'b1, 1'b1, 1'b1);
        add(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
`else
        add(1'b1, 1'b1, 3'd2, 8'h04, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 3'd6, 8'h04, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 3'd6, 8'h04, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 3'd6, 8'h04, 1'b0, 1'b1, 1'b1);
        add(1'b1, 1'b1, 3'd6, 8'h00, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 3'd6, 8'h40, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 3'd0, 8'h40, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 3'd0, 8'h40, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 3'd0, 8'h40, 1'b0, 1'b1, 1'b1);
        add(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n_v[0] = tbl[i].rst_n;
            valid_v[0] = tbl[i].valid;
            code_v[0]  = tbl[i].code;
            @(negedge clk);
            chk8($sformatf("tbl%0d_line", i), line_v[0], tbl[i].line);
            chk1($sformatf("tbl%0d_ready", i), ready_v[0], tbl[i].ready);
            chk1($sformatf("tbl%0d_busy", i), busy_v[0], tbl[i].busy);
            chk1($sformatf("tbl%0d_done", i), done_v[0], tbl[i].done);
        end

        // Sweep codes 0..7 through the single-cycle instance.
        rst_n_v[1] = 1'b1;
        cyc();
        cyc();
        for (int c = 0; c < 8; c++) begin
            valid_v[1] = 1'b1;
            code_v[1]  = 3'(c);
            n = 0;
            do begin
                cyc();
                seen.push_back(line_v[1]);
                n++;
            end while (m_acc[1] == 0 && n < 10);
            chki("sweep_accept_bound", (n < 10) ? 1 : 0, 1);
        end
        valid_v[1] = 1'b0;
        repeat (3) begin
            cyc();
            seen.push_back(line_v[1]);
        end
        gaps = 0;
        zrun = 0;
        foreach (seen[i]) begin
            if (seen[i] != 8'h00) begin
                if (nz.size() > 0 && zrun > 0) gaps++;
                nz.push_back(seen[i]);
                zrun = 0;
            end else begin
                zrun++;
            end
        end
        chki("sweep_count", nz.size(), 8);
        for (int i = 0; i < 8 && i < nz.size(); i++) chk8("sweep_walk", nz[i], 8'(32'd1 << i));
        chki("sweep_gaps", gaps, SKID ? 0 : 7);

        // Reset during the second hold cycle of code 7 with a second code pending.
        valid_v[0] = 1'b1;
        code_v[0]  = 3'd7;
        cyc();
        chk8("mid_first", line_v[0], 8'h80);
        code_v[0] = 3'd3;
        cyc();
        valid_v[0] = 1'b0;
        rst_n_v[0] = 1'b0;
        cyc();
        chk8("mid_rst_line", line_v[0], 8'h00);
        chk1("mid_rst_busy", busy_v[0], 1'b0);
        rst_n_v[0] = 1'b1;
        dones = 0;
        held  = 0;
        repeat (8) begin
            cyc();
            if (done_v[0] === 1'b1) dones++;
            if (line_v[0] !== 8'h00) held++;
        end
        chki("mid_rst_done", dones, 0);
        chki("mid_rst_lost", held, 0);

        // Code toggles with valid low: nothing may start.
        for (int i = 0; i < 20; i++) begin
            code_v[0] = 3'($urandom_range(0, 7));
            cyc();
            chk8("novalid_line", line_v[0], 8'h00);
            chk1("novalid_busy", busy_v[0], 1'b0);
        end

        // Random traffic with sporadic resets on both instances.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                rst_n_v[k] = ($urandom_range(0, 39) != 0);
                valid_v[k] = ($urandom_range(0, 2) != 0);
                code_v[k]  = 3'($urandom_range(0, 7));
            end
            cyc();
        end
        rst_n_v = 2'b11;
        valid_v = 2'b00;
        repeat (6) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
